adder_4_bit: RTL and testbench



---
 rtl/adder_4_bit_pkg.sv | 15 +
 rtl/adder_4_bit_full_adder.sv | 21 ++
 rtl/adder_4_bit.sv | 56 +++++
 tb/tb_adder_4_bit.sv | 119 +++++++++++
 4 files changed

// File: rtl/adder_4_bit_pkg.sv
// ============================================================================
// Module      : adder_4_bit_pkg
// Description : Shared width constants for the registered ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_4_bit_pkg;

    localparam int c_WIDTH_DEFAULT  = 4;
    localparam int c_RESULT_WIDTH   = c_WIDTH_DEFAULT + 1;

endpackage : adder_4_bit_pkg

`default_nettype wire

// File: rtl/adder_4_bit_full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : One-bit combinational full adder, the ripple-chain cell.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

`default_nettype wire

// File: rtl/adder_4_bit.sv
// ============================================================================
// Module      : adder_4_bit
// Description : Unsigned ripple-carry adder with registered Sum/Cout outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_4_bit
    import adder_4_bit_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    // No external carry-in: the chain starts from zero.
    assign w_carry[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ripple
            full_adder u_fa (
                .a    (A[gi]),
                .b    (B[gi]),
                .cin  (w_carry[gi]),
                .s    (w_sum[gi]),
                .cout (w_carry[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry[WIDTH];
        end
    end

    assign Sum  = r_sum;
    assign Cout = r_cout;

endmodule : adder_4_bit

`default_nettype wire

// File: tb/tb_adder_4_bit.sv
// ============================================================================
// Module      : tb_adder_4_bit
// Description : Self-checking bench for adder_4_bit against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adder_4_bit;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [3:0] Sum;
    logic       Cout;

    int checks = 0;
    int errors = 0;

    int model_val   = 0;
    bit model_valid = 1'b0;

    adder_4_bit #(.WIDTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Sum  (Sum),
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: the registered result is simply A+B as seen at the last edge, or 0 under reset.
    always @(posedge clk) begin
        model_val   <= rst ? 0 : (int'(A) + int'(B));
        model_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid)
            chk("model_compare", {Cout, Sum}, 5'(model_val));
    end

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic r);
        A   = a;
        B   = b;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ra, rb;
        logic       rr;
        rst = 1'b1;
        A   = 4'hF;
        B   = 4'hF;

        step(4'hF, 4'hF, 1'b1); chk("reset_edge1", {Cout, Sum}, 5'h00);
        step(4'hF, 4'hF, 1'b1); chk("reset_edge2", {Cout, Sum}, 5'h00);
        step(4'hF, 4'hF, 1'b0); chk("reset_release", {Cout, Sum}, 5'h1E);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(4'(a), 4'(b), 1'b0);
                chk("sweep_first", {Cout, Sum}, 5'(a + b));
                step(4'(a), 4'(b), 1'b0);
                chk("sweep_hold", {Cout, Sum}, 5'(a + b));
                step(4'(a), 4'(b), 1'b0);
                chk("sweep_hold", {Cout, Sum}, 5'(a + b));
            end
        end

        step(4'h8, 4'h8, 1'b0); chk("carry_8_8", {Cout, Sum}, 5'h10);
        step(4'h7, 4'h8, 1'b0); chk("carry_7_8", {Cout, Sum}, 5'h0F);
        step(4'hF, 4'h1, 1'b0); chk("carry_full_ripple", {Cout, Sum}, 5'h10);
        step(4'h0, 4'h0, 1'b0); chk("zero", {Cout, Sum}, 5'h00);
        step(4'h5, 4'h0, 1'b0); chk("identity", {Cout, Sum}, 5'h05);

        step(4'h1, 4'h2, 1'b0); chk("stream_1_2", {Cout, Sum}, 5'h03);
        step(4'h3, 4'h4, 1'b0); chk("stream_3_4", {Cout, Sum}, 5'h07);
        step(4'h9, 4'h9, 1'b0); chk("stream_9_9", {Cout, Sum}, 5'h12);
        #2;
        A = 4'h0;
        B = 4'h1;
        #1;
        chk("mid_cycle_hold", {Cout, Sum}, 5'h12);
        @(posedge clk); #1;
        chk("after_mid_change", {Cout, Sum}, 5'h01);

        step(4'h6, 4'h7, 1'b0); chk("stream_6_7", {Cout, Sum}, 5'h0D);
        step(4'h6, 4'h7, 1'b1); chk("midstream_reset", {Cout, Sum}, 5'h00);
        step(4'h6, 4'h7, 1'b0); chk("post_reset_6_7", {Cout, Sum}, 5'h0D);

        for (int i = 0; i < 300; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 15) == 0);
            step(ra, rb, rr);
            chk("random", {Cout, Sum}, rr ? 5'h00 : (5'(ra) + 5'(rb)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_adder_4_bit

`default_nettype wire
